// File: rtl/frame_pkg.sv
// frame_pkg: state types, byte-select constants and width helper for the frame capture path
package frame_pkg;
    typedef enum logic [1:0] {P_IDLE, P_WAIT_HI, P_WAIT_LO} pix_state_t;
    typedef enum logic {M_IDLE, M_WAIT_ACK} mem_state_t;
    localparam logic [1:0] SEL_ALL = 2'b11;
    localparam logic [1:0] SEL_NONE = 2'b00;
    function automatic int total_w(input int range);
        return 2 * range;
    endfunction
endpackage

// File: rtl/frame_capture_if.sv
// frame_capture_if: pixel strobe handshake plus frame memory write bus
interface frame_capture_if #(
    parameter int DBUS = 16,
    parameter int ADDW = 18
);
    logic [DBUS-1:0] pix_dat;
    logic            pix_pclk;
    logic            pix_cyc;
    logic            mem_cyc;
    logic            mem_ack;
    logic [DBUS-1:0] dat;
    logic [ADDW-1:0] adr;
    logic            stb;
    logic            we;
    logic [1:0]      sel;
    logic            cyc;
    modport master (
        input  pix_dat, pix_pclk, mem_cyc, mem_ack,
        output pix_cyc, dat, adr, stb, we, sel, cyc
    );
    modport slave (
        output pix_dat, pix_pclk, mem_cyc, mem_ack,
        input  pix_cyc, dat, adr, stb, we, sel, cyc
    );
endinterface

// File: rtl/pix_fifo.sv
// pix_fifo: small synchronous pixel buffer; extra pointer bit separates full from empty
module pix_fifo #(
    parameter int DBUS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push,
    input  logic            pop,
    input  logic [DBUS-1:0] din,
    output logic [DBUS-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DBUS-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    assign dout = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    always_ff @(posedge clk_i)
        if (push && !full) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
endmodule

// File: rtl/frame_capture.sv
// frame_capture: accepts a width*height pixel frame over a strobe handshake and writes it to memory
module frame_capture
    import frame_pkg::*;
#(
    parameter int RANGE = 9,
    parameter int ADDW = 18,
    parameter int DBUS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             arm,
    input  logic [RANGE-1:0] width,
    input  logic [RANGE-1:0] height,
    input  logic [ADDW-1:0]  adr_i,
    input  logic             irq_clear,
    output logic             busy,
    output logic             irq,
    frame_capture_if.master  bus
);
    localparam int TW = total_w(RANGE);
    pix_state_t       pst;
    mem_state_t       mst;
    logic             arm_ok, push, pop, full, empty, done;
    logic             pc_q, stb_q, we_q, cyc_q;
    logic [1:0]       sel_q;
    logic [ADDW-1:0]  adr_reg, adr_q;
    logic [DBUS-1:0]  dat_q, head;
    logic [TW-1:0]    total, arm_total, accepted, written;
    logic [RANGE-1:0] width_reg, dot, line;

    assign arm_ok = arm && !busy;
    assign arm_total = TW'(width) * TW'(height);
    assign push = pst == P_WAIT_HI && bus.pix_pclk && !full && accepted < total;
    assign pop = mst == M_WAIT_ACK && bus.mem_ack;
    assign done = busy && written == total;
    assign bus.pix_cyc = pc_q;
    assign bus.stb = stb_q;
    assign bus.we = we_q;
    assign bus.sel = sel_q;
    assign bus.cyc = cyc_q;
    assign bus.adr = adr_q;
    assign bus.dat = dat_q;

    pix_fifo #(.DBUS(DBUS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .pop(pop),
        .din(bus.pix_dat), .dout(head), .full(full), .empty(empty)
    );

    // an arm landing while the last strobe is still falling must not be lost
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            pst <= P_IDLE;
            pc_q <= 1'b0;
            total <= '0;
            accepted <= '0;
            width_reg <= '0;
            dot <= '0;
            line <= '0;
        end else begin
            if (arm_ok) begin
                total <= arm_total;
                width_reg <= width;
                accepted <= '0;
                dot <= '0;
                line <= '0;
            end
            case (pst)
                P_IDLE: if (arm_ok && arm_total != '0) pst <= P_WAIT_HI;
                P_WAIT_HI: if (push) begin
                    accepted <= accepted + 1'b1;
                    dot <= (dot == width_reg - 1'b1) ? '0 : dot + 1'b1;
                    if (dot == width_reg - 1'b1) line <= line + 1'b1;
                    pc_q <= 1'b1;
                    pst <= P_WAIT_LO;
                end
                P_WAIT_LO: if (!bus.pix_pclk) begin
                    pc_q <= 1'b0;
                    pst <= (accepted == total && !arm_ok) ? P_IDLE : P_WAIT_HI;
                end
                default: pst <= P_IDLE;
            endcase
        end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            mst <= M_IDLE;
            stb_q <= 1'b0;
            we_q <= 1'b0;
            sel_q <= SEL_NONE;
            cyc_q <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            adr_reg <= '0;
            written <= '0;
            busy <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (arm_ok) begin
                adr_reg <= adr_i;
                written <= '0;
            end
            busy <= arm_ok ? arm_total != '0 : busy && !done;
            irq <= (arm_ok && arm_total == '0) || done || (irq && !irq_clear);
            stb_q <= 1'b0;
            case (mst)
                M_IDLE: if (!empty && !bus.mem_cyc) begin
                    stb_q <= 1'b1;
                    we_q <= 1'b1;
                    sel_q <= SEL_ALL;
                    cyc_q <= 1'b1;
                    adr_q <= adr_reg;
                    dat_q <= head;
                    mst <= M_WAIT_ACK;
                end
                M_WAIT_ACK: if (bus.mem_ack) begin
                    adr_reg <= adr_reg + 1'b1;
                    written <= written + 1'b1;
                    we_q <= 1'b0;
                    sel_q <= SEL_NONE;
                    cyc_q <= 1'b0;
                    adr_q <= '0;
                    mst <= M_IDLE;
                end
                default: mst <= M_IDLE;
            endcase
        end
endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed checks of capture, back-pressure, contention, wrap, irq corners and reset
module tb_frame_capture;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        arm = 1'b0;
    logic        irq_clear = 1'b0;
    logic [8:0]  width = '0;
    logic [8:0]  height = '0;
    logic [17:0] adr_i = '0;
    logic        busy, irq;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cnt;
    logic [17:0] log_adr[$];
    logic [15:0] log_dat[$];

    frame_capture_if #(.DBUS(16), .ADDW(18)) bus ();

    frame_capture #(.RANGE(9), .ADDW(18), .DBUS(16), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .arm(arm), .width(width), .height(height),
        .adr_i(adr_i), .irq_clear(irq_clear), .busy(busy), .irq(irq), .bus(bus.master)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (rst_ni && bus.stb) begin
            log_adr.push_back(bus.adr);
            log_dat.push_back(bus.dat);
        end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_frame(input logic [8:0] w, input logic [8:0] h, input logic [17:0] a);
        width = w;
        height = h;
        adr_i = a;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        bus.pix_dat = d;
        bus.pix_pclk = 1'b1;
        for (int i = 0; i < 60 && !bus.pix_cyc; i++) tick();
        chk("pix_ack_hi", bus.pix_cyc, 1);
        bus.pix_pclk = 1'b0;
        for (int i = 0; i < 60 && bus.pix_cyc; i++) tick();
        chk("pix_ack_lo", bus.pix_cyc, 0);
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 300 && !irq; i++) tick();
        chk(tag, irq, 1);
    endtask

    task automatic clear_irq();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("irq_cleared", irq, 0);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [17:0] a, input logic [15:0] d);
        chk({tag, "_adr"}, idx < log_adr.size() ? 64'(log_adr[idx]) : 'x, 64'(a));
        chk({tag, "_dat"}, idx < log_dat.size() ? 64'(log_dat[idx]) : 'x, 64'(d));
    endtask

    initial begin
        bus.pix_dat = '0;
        bus.pix_pclk = 1'b0;
        bus.mem_cyc = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_outs", {bus.stb, bus.cyc, bus.we, bus.sel, bus.pix_cyc}, 0);
        chk("rst_adr", bus.adr, 0);
        rst_ni = 1'b1;
        tick();

        // basic 4x2 frame with immediate ack
        bus.mem_ack = 1'b1;
        arm_frame(9'd4, 9'd2, 18'h100);
        chk("t1_busy", busy, 1);
        bus.pix_dat = 16'h1000;
        bus.pix_pclk = 1'b1;
        tick();
        chk("t1_pcyc_n1", bus.pix_cyc, 1);
        chk("t1_stb_n1", bus.stb, 0);
        tick();
        chk("t1_stb_n2", {bus.stb, bus.cyc, bus.we, bus.sel}, 5'b11111);
        chk("t1_adr_n2", bus.adr, 18'h100);
        chk("t1_dat_n2", bus.dat, 16'h1000);
        bus.pix_pclk = 1'b0;
        tick();
        chk("t1_after_ack", {bus.stb, bus.cyc, bus.we, bus.sel, bus.pix_cyc}, 0);
        for (int i = 1; i < 8; i++) send(16'h1000 + 16'(i));
        wait_irq("t1_irq");
        chk("t1_busy_done", busy, 0);
        chk("t1_nwrites", log_adr.size(), 8);
        for (int i = 0; i < 8; i++) chk_log("t1_w", i, 18'h100 + 18'(i), 16'h1000 + 16'(i));

        // back-pressure: ack withheld, FIFO fills at 4
        clear_irq();
        log_adr.delete();
        log_dat.delete();
        bus.mem_ack = 1'b0;
        arm_frame(9'd6, 9'd1, 18'h200);
        for (int i = 0; i < 4; i++) send(16'h2000 + 16'(i));
        bus.pix_dat = 16'h2004;
        bus.pix_pclk = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (bus.pix_cyc) cnt++;
        end
        chk("t2_stalled", cnt, 0);
        chk("t2_one_stb", log_adr.size(), 1);
        chk("t2_cyc_held", bus.cyc, 1);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 20 && !bus.pix_cyc; i++) tick();
        chk("t2_resume", bus.pix_cyc, 1);
        bus.pix_pclk = 1'b0;
        for (int i = 0; i < 20 && bus.pix_cyc; i++) tick();
        send(16'h2005);
        wait_irq("t2_irq");
        chk("t2_nwrites", log_adr.size(), 6);
        for (int i = 0; i < 6; i++) chk_log("t2_w", i, 18'h200 + 18'(i), 16'h2000 + 16'(i));

        // bus contention
        clear_irq();
        log_adr.delete();
        log_dat.delete();
        bus.mem_cyc = 1'b1;
        arm_frame(9'd2, 9'd1, 18'h300);
        send(16'h3000);
        cnt = 0;
        repeat (10) begin
            tick();
            if (bus.stb || bus.cyc) cnt++;
        end
        chk("t3_no_bus", cnt, 0);
        bus.mem_cyc = 1'b0;
        tick();
        chk("t3_stb_after", bus.stb, 1);
        chk("t3_adr_after", bus.adr, 18'h300);
        send(16'h3001);
        wait_irq("t3_irq");
        chk_log("t3_w1", 1, 18'h301, 16'h3001);

        // address wrap, then zero-size frame
        clear_irq();
        log_adr.delete();
        log_dat.delete();
        arm_frame(9'd3, 9'd1, 18'h3FFFE);
        for (int i = 0; i < 3; i++) send(16'h4000 + 16'(i));
        wait_irq("t4_irq");
        chk_log("t4_w0", 0, 18'h3FFFE, 16'h4000);
        chk_log("t4_w1", 1, 18'h3FFFF, 16'h4001);
        chk_log("t4_w2", 2, 18'h00000, 16'h4002);
        clear_irq();
        log_adr.delete();
        log_dat.delete();
        arm_frame(9'd0, 9'd5, 18'h1234);
        chk("t4_zero_irq", irq, 1);
        chk("t4_zero_busy", busy, 0);
        bus.pix_pclk = 1'b1;
        cnt = 0;
        repeat (6) begin
            tick();
            if (bus.stb || bus.pix_cyc) cnt++;
        end
        bus.pix_pclk = 1'b0;
        chk("t4_zero_quiet", cnt, 0);
        chk("t4_zero_nwr", log_adr.size(), 0);

        // irq set beats clear, arm while busy ignored, held strobe counts once
        irq_clear = 1'b1;
        arm_frame(9'd2, 9'd1, 18'h500);
        chk("t5_busy", busy, 1);
        arm_frame(9'd2, 9'd1, 18'h600);
        bus.pix_dat = 16'h5000;
        bus.pix_pclk = 1'b1;
        repeat (5) tick();
        chk("t5_held_ack", bus.pix_cyc, 1);
        bus.pix_pclk = 1'b0;
        for (int i = 0; i < 20 && bus.pix_cyc; i++) tick();
        send(16'h5001);
        wait_irq("t5_set_wins");
        tick();
        chk("t5_clear_after", irq, 0);
        irq_clear = 1'b0;
        chk("t5_nwrites", log_adr.size(), 2);
        chk_log("t5_w0", 0, 18'h500, 16'h5000);
        chk_log("t5_w1", 1, 18'h501, 16'h5001);

        // reset in M_WAIT_ACK, then a fresh 2x2 frame
        log_adr.delete();
        log_dat.delete();
        bus.mem_ack = 1'b0;
        arm_frame(9'd2, 9'd2, 18'h700);
        send(16'h6000);
        for (int i = 0; i < 20 && !bus.cyc; i++) tick();
        chk("t6_in_wait", bus.cyc, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_ctl", {bus.stb, bus.cyc, bus.we, bus.sel, bus.pix_cyc, busy, irq}, 0);
        chk("t6_rst_adr", bus.adr, 0);
        chk("t6_rst_dat", bus.dat, 0);
        tick();
        rst_ni = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        log_adr.delete();
        log_dat.delete();
        arm_frame(9'd2, 9'd2, 18'h800);
        for (int i = 0; i < 4; i++) send(16'h6100 + 16'(i));
        wait_irq("t6_irq");
        chk("t6_busy", busy, 0);
        chk("t6_nwrites", log_adr.size(), 4);
        for (int i = 0; i < 4; i++) chk_log("t6_w", i, 18'h800 + 18'(i), 16'h6100 + 16'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
